// File: rtl/rolling_stats.sv
// rolling_stats: sliding-window mean and mean-of-squares over the last WINDOW
// 8-bit samples. The window is a circular buffer with running sum and square-sum.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_valid   data_in carries a new sample this cycle
//   data_in      unsigned 8-bit sample
//   clear        synchronous flush of the window (wins over data_valid)
//   N_mean       floor(sum of window / WINDOW)
//   N_sqr_mean   floor(sum of squares of window / WINDOW)
//   current_data most recently accepted sample
//   stats_valid  window is full
//   stats_update one-cycle pulse per accepted sample while the window is full
module rolling_stats #(
  parameter int unsigned WINDOW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic        clear,
  output logic [7:0]  N_mean,
  output logic [15:0] N_sqr_mean,
  output logic [7:0]  current_data,
  output logic        stats_valid,
  output logic        stats_update
);

  localparam int unsigned LOG2W = $clog2(WINDOW);
  localparam int unsigned SUM_W = 8 + LOG2W;
  localparam int unsigned SQ_W  = 16 + LOG2W;
  localparam int unsigned CNT_W = LOG2W + 1;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SQ_W-1:0]    sq_q, sq_d;
  logic [CNT_W-1:0]   fill_q, fill_d;
  logic [LOG2W-1:0]   ptr_q, ptr_d;
  logic [7:0]         cur_q, cur_d;
  logic               valid_q, valid_d;
  logic               upd_q, upd_d;

  logic [7:0]         buf_mem [WINDOW];
  logic [7:0]         evicted;
  logic [15:0]        din_sq;
  logic [15:0]        ev_sq;
  logic               accept;

  assign accept  = data_valid & ~clear;
  // Read the slot about to be overwritten; it is the oldest sample once in RUN.
  assign evicted = buf_mem[ptr_q];
  assign din_sq  = 16'(data_in) * 16'(data_in);
  assign ev_sq   = 16'(evicted) * 16'(evicted);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the WINDOW-th accepted sample moves FILL to RUN
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FILL;
    end else if (data_valid && (state_q == FILL) &&
                 (fill_q == CNT_W'(WINDOW - 1))) begin
      state_d = RUN;
    end
  end

  // Datapath / output next values
  always_comb begin
    sum_d   = sum_q;
    sq_d    = sq_q;
    fill_d  = fill_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    valid_d = (state_d == RUN);
    upd_d   = 1'b0;
    if (clear) begin
      sum_d  = '0;
      sq_d   = '0;
      fill_d = '0;
      ptr_d  = '0;
      cur_d  = '0;
    end else if (data_valid) begin
      ptr_d = ptr_q + LOG2W'(1);
      cur_d = data_in;
      upd_d = (state_d == RUN);
      if (state_q == FILL) begin
        sum_d  = sum_q + SUM_W'(data_in);
        sq_d   = sq_q + SQ_W'(din_sq);
        fill_d = fill_q + CNT_W'(1);
      end else begin
        // Evicted value is part of the current sums, so subtraction never underflows.
        sum_d = sum_q + SUM_W'(data_in) - SUM_W'(evicted);
        sq_d  = sq_q + SQ_W'(din_sq) - SQ_W'(ev_sq);
      end
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      sq_q    <= '0;
      fill_q  <= '0;
      ptr_q   <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      sq_q    <= sq_d;
      fill_q  <= fill_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
    end
  end

  // Sample storage; contents are only read after being written in this window
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[ptr_q] <= data_in;
    end
  end

  // Division by WINDOW is a slice of the registered sums
  assign N_mean       = sum_q[SUM_W-1:LOG2W];
  assign N_sqr_mean   = sq_q[SQ_W-1:LOG2W];
  assign current_data = cur_q;
  assign stats_valid  = valid_q;
  assign stats_update = upd_q;

endmodule

// File: doc/rolling_stats.md
ROLLING_STATS -- requirements
Module: rolling_stats

Interface
REQ-001 SHALL provide parameter WINDOW, default 16, sliding window length in samples; power of two, 2..256.
REQ-002 SHALL derive LOG2W = log2(WINDOW) internally; it SHALL NOT be a user parameter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 data_valid  input  1  data_in carries a new price sample this cycle.
REQ-007 data_in  input  8  unsigned price sample.
REQ-008 clear  input  1  synchronous flush of the window, active high.
REQ-009 N_mean  output  8  floor(sum of window / WINDOW).
REQ-010 N_sqr_mean  output  16  floor(sum of squares of window / WINDOW).
REQ-011 current_data  output  8  most recently accepted sample, aligned with N_mean and N_sqr_mean.
REQ-012 stats_valid  output  1  window is full and the statistics are meaningful.
REQ-013 stats_update  output  1  one-cycle pulse marking a new statistics set while stats_valid is high.

Function
REQ-014 SHALL hold WINDOW 8-bit samples in a circular buffer with a LOG2W-bit write pointer that wraps from WINDOW-1 to 0.
REQ-015 SHALL keep a running sum of width 8+LOG2W and a running square-sum of width 16+LOG2W, with no overflow at any input.
REQ-016 SHALL use two states: FILL (fewer than WINDOW samples held) and RUN (window full).
REQ-017 SHALL, on a data_valid=1 edge, write data_in to buffer[wr_ptr], advance wr_ptr, and update both sums.
REQ-018 SHALL, in FILL, add data_in to sum and data_in^2 to square-sum without subtraction, and increment the fill counter.
REQ-019 SHALL, in RUN, add data_in and subtract the evicted buffer[wr_ptr] value read before the overwrite; for the square-sum, add data_in^2 and subtract the evicted value squared.
REQ-020 SHALL transition FILL->RUN on the edge that accepts the WINDOW-th sample, and assert stats_valid on that same edge.
REQ-021 SHALL, in RUN, stay in RUN on every edge unless clear=1, and keep stats_valid at 1.
REQ-022 SHALL drive N_mean = sum>>LOG2W and N_sqr_mean = square-sum>>LOG2W directly from registers, giving latency 1 edge from sample acceptance to output.
REQ-023 SHALL register current_data <= data_in on every accepted sample, including samples accepted in FILL.
REQ-024 SHALL pulse stats_update high for exactly the cycle following each accepted sample when the post-update state is RUN, including the WINDOW-th sample.
REQ-025 SHALL hold all state and outputs when data_valid=0 and clear=0, and SHALL keep stats_update at 0.
REQ-026 SHALL, on clear=1, zero the sums, fill counter, wr_ptr, outputs, stats_valid and stats_update, and enter FILL; buffer contents need not be cleared.
REQ-027 SHALL give clear priority when clear=1 and data_valid=1 occur in the same cycle, discarding the sample.
REQ-028 SHALL guarantee N_mean*N_mean <= N_sqr_mean at all times, so that the downstream variance never underflows.
REQ-029 SHALL contain no combinational path from any input to any output.

Reset
REQ-030 SHALL, on rst_n=0 at any time (including mid-fill or mid-RUN), immediately force N_mean=0, N_sqr_mean=0, current_data=0, stats_valid=0, stats_update=0, sums=0, fill counter=0, wr_ptr=0 and state=FILL.
REQ-031 SHALL accept the first sample on the first rising edge after rst_n deasserts with data_valid=1.

Verification
REQ-032 WINDOW=4; feed 10,20,30,40 on consecutive cycles -> after the 4th edge: N_mean=25, N_sqr_mean=750, current_data=40, stats_valid=1, stats_update=1 for one cycle.
REQ-033 Continue from REQ-032 with 50 -> N_mean=35, N_sqr_mean=1350 (10 evicted); stats_update pulses once.
REQ-034 WINDOW=4; feed 255 x4 -> N_mean=255, N_sqr_mean=65025, no wrap; then feed 0 -> N_mean=191, N_sqr_mean=48768.
REQ-035 WINDOW=4; feed 3 samples, then clear=1 together with data_valid=1 -> all outputs 0, stats_valid=0; the next 4 samples are needed before stats_valid=1.
REQ-036 In RUN, assert rst_n=0 between clock edges -> outputs are 0 before the next edge; data_valid gaps hold outputs unchanged and stats_update stays 0.
REQ-037 Random stimulus of 10^5 samples with random data_valid, checked against a reference model -> exact match every cycle and N_mean^2 <= N_sqr_mean always.
